// File: rtl/speck_pkg.sv
`default_nettype none
// ============================================================================
// Module      : speck_pkg
// Description : Shared constants, FSM state type, round-key file type and
//               16-bit rotate helpers for the SPECK32/64 decryption core.
// Revision    : 1.0 - initial release
// ============================================================================
package speck_pkg;

  localparam int WORD_W = 16;
  localparam int ROUNDS = 22;
  localparam int ALPHA  = 7;
  localparam int BETA   = 2;

  // Round counter holds 0..ROUNDS-1
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] KEYEXP_LAST = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] DEC_FIRST   = CNT_W'(ROUNDS - 1);

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t rk_file_t [ROUNDS];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    DEC    = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic word_t rol(input word_t v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  function automatic word_t ror(input word_t v, input int unsigned s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

endpackage
`default_nettype wire

// File: rtl/speck_dec_round.sv
`default_nettype none
// ============================================================================
// Module      : speck_dec_round
// Description : One combinational SPECK32/64 inverse round:
//               y' = ROR(x ^ y, BETA); x' = ROL((x ^ rk) - y', ALPHA)
// Revision    : 1.0 - initial release
// ============================================================================
module speck_dec_round
  import speck_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] rk,
  output logic [WORD_W-1:0] x_next,
  output logic [WORD_W-1:0] y_next
);

  logic [WORD_W-1:0] w_y;

  // Undo the y update first, then use it to undo the modular add on x
  always_comb begin
    w_y    = ror(x ^ y, BETA);
    x_next = rol((x ^ rk) - w_y, ALPHA);
    y_next = w_y;
  end

endmodule
`default_nettype wire

// File: rtl/speck_decrypt_core.sv
`default_nettype none
// ============================================================================
// Module      : speck_decrypt_core
// Description : SPECK32/64 block decryption. Accepts key/ciphertext, expands
//               round keys forward (21 cycles), then runs 22 inverse rounds
//               in reverse key order and presents the plaintext.
//               Optional macro SPECK_DEC_KEY_CACHE_EN keeps the expanded key
//               file and lets key_reuse skip key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
module speck_decrypt_core
  import speck_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] key,
  input  logic [31:0] ct,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] pt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  input  logic        key_reuse
);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_x;
  logic [WORD_W-1:0] r_y;
  logic [WORD_W-1:0] r_kcur;
  logic [WORD_W-1:0] r_l0;
  logic [WORD_W-1:0] r_l1;
  logic [WORD_W-1:0] r_l2;
  rk_file_t          r_rk;

  logic              w_accept;
  logic              w_skip_kexp;
  logic [WORD_W-1:0] w_l_new;
  logic [WORD_W-1:0] w_knext;
  logic [WORD_W-1:0] w_rk_dec;
  logic [WORD_W-1:0] w_x_next;
  logic [WORD_W-1:0] w_y_next;

  assign w_accept = in_valid && (r_state == IDLE);

`ifdef SPECK_DEC_KEY_CACHE_EN
  logic r_rk_valid;

  // Cached-key flag: dropped when a new expansion starts, set once it completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rk_valid <= 1'b0;
    end else if (w_accept && !w_skip_kexp) begin
      r_rk_valid <= 1'b0;
    end else if (r_state == KEYEXP && w_next_state == DEC) begin
      r_rk_valid <= 1'b1;
    end
  end

  assign w_skip_kexp = key_reuse && r_rk_valid;
`else
  logic w_unused_key_reuse;
  assign w_unused_key_reuse = key_reuse;
  assign w_skip_kexp        = 1'b0;
`endif

  // Key-schedule step for round index r_cnt; l[i] is the head of the l queue
  assign w_l_new  = (r_kcur + ror(r_l0, ALPHA)) ^ WORD_W'(r_cnt);
  assign w_knext  = rol(r_kcur, BETA) ^ w_l_new;
  assign w_rk_dec = r_rk[r_cnt];

  speck_dec_round u_round (
    .x      (r_x),
    .y      (r_y),
    .rk     (w_rk_dec),
    .x_next (w_x_next),
    .y_next (w_y_next)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:   if (w_accept) w_next_state = w_skip_kexp ? DEC : KEYEXP;
      KEYEXP: if (r_cnt == KEYEXP_LAST) w_next_state = DEC;
      DEC:    if (r_cnt == '0) w_next_state = OUT;
      OUT:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output decode; pt is forced to zero outside OUT so stale data never leaks
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == OUT);
    busy      = (r_state != IDLE);
    pt        = (r_state == OUT) ? {r_x, r_y} : 32'h0;
  end

  // Datapath: capture on accept, step the key schedule, then inverse rounds
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_kcur <= '0;
      r_l0   <= '0;
      r_l1   <= '0;
      r_l2   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x <= ct[31:16];
            r_y <= ct[15:0];
            if (w_skip_kexp) begin
              r_cnt <= DEC_FIRST;
            end else begin
              r_cnt  <= '0;
              r_kcur <= key[15:0];
              r_l0   <= key[31:16];
              r_l1   <= key[47:32];
              r_l2   <= key[63:48];
            end
          end
        end
        KEYEXP: begin
          // At the last step this lands on DEC_FIRST naturally
          r_cnt  <= r_cnt + CNT_W'(1);
          r_kcur <= w_knext;
          r_l0   <= r_l1;
          r_l1   <= r_l2;
          r_l2   <= w_l_new;
        end
        DEC: begin
          r_x <= w_x_next;
          r_y <= w_y_next;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Round-key file: no reset needed, always written before it is read
  always_ff @(posedge clk) begin
    if (w_accept && !w_skip_kexp) begin
      r_rk[0] <= key[15:0];
    end else if (r_state == KEYEXP) begin
      r_rk[r_cnt + CNT_W'(1)] <= w_knext;
    end
  end

endmodule
`default_nettype wire
